// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_t    - FSM state encoding
//   SIZE_*         - request access-size codes
//   MEM_SEL_WORD   - BYTE_SEL value presented to the word-wide data memory
//   is_misaligned  - alignment / legal-size check on an incoming request
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD_RSP,
    ST_RMW_WRITE,
    ST_WRITE,
    ST_STORE_RSP,
    ST_ERROR
  } lsu_state_t;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] MEM_SEL_WORD = 2'b10;

  // Size 2'b11 is not a real access size, so it is treated like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response channel from the execute stage plus the
// data-memory port driven by the load/store unit.
//   slave  - the load/store unit's view (takes requests, drives memory)
//   master - the surrounding system's view (issues requests, is the memory)
interface load_store_unit_if #(
  parameter int ADDR_DEPTH = 14
);
  // execute-stage request / response
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  // data-memory port
  logic                  mem_rden;
  logic                  mem_wen;
  logic [1:0]            mem_byte_sel;
  logic                  mem_sign;
  logic [ADDR_DEPTH-1:0] mem_addr;
  logic [31:0]           mem_data_in;
  logic [31:0]           mem_data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_rden, mem_wen, mem_byte_sel, mem_sign, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_rden, mem_wen, mem_byte_sel, mem_sign, mem_addr, mem_data_in
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: purely combinational byte-lane handling.
//   size, is_unsigned, byte_off - latched request attributes
//   rd_word                     - word read from memory
//   wdata                       - right-justified store data
//   load_data                   - extracted and sign/zero-extended load result
//   store_word                  - write word (full wdata, or rd_word with lanes merged)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  assign shifted = rd_word >> {byte_off, 3'b000};

  always_comb begin
    load_data = rd_word;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default:   load_data = rd_word;
    endcase
  end

  // Per lane: take the new byte when this lane is covered by the store,
  // otherwise keep what memory already holds.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = gi;
      logic hit_byte;
      logic hit_half;
      assign hit_byte = (size == SIZE_BYTE) && (byte_off == LANE);
      assign hit_half = (size == SIZE_HALF) && (byte_off[1] == LANE[1]);
      assign store_word[8*gi +: 8] =
          (size == SIZE_WORD) ? wdata[8*gi +: 8] :
          hit_byte            ? wdata[7:0] :
          hit_half            ? wdata[8*(gi%2) +: 8] :
                                rd_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
//   CLK, RST_N - rising-edge clock, asynchronous active-low reset
//   bus        - load_store_unit_if.slave: execute-stage request/response and
//                the word-wide data-memory port (BYTE_SEL fixed to WORD)
// Sub-word stores are done as read-modify-write; misaligned or illegal-size
// requests complete with rsp_err and never touch memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_DEPTH = 14
) (
  input  logic              CLK,
  input  logic              RST_N,
  load_store_unit_if.slave  bus
);

  lsu_state_t            state_reg;
  logic                  ready_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_err_reg;
  logic                  rden_reg;
  logic                  wen_reg;
  logic [ADDR_DEPTH-1:0] waddr_reg;
  logic [1:0]            off_reg;
  logic [1:0]            size_reg;
  logic                  we_reg;
  logic                  unsigned_reg;
  logic [31:0]           wdata_reg;

  logic [31:0]           load_data;
  logic [31:0]           store_word;

  // Control outputs are registered: each one is set on the edge entering the
  // state that owns it, so it is high for exactly that state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rden_reg      <= 1'b0;
      wen_reg       <= 1'b0;
      waddr_reg     <= '0;
      off_reg       <= 2'b00;
      size_reg      <= 2'b00;
      we_reg        <= 1'b0;
      unsigned_reg  <= 1'b0;
      wdata_reg     <= 32'h0;
    end else begin
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rden_reg      <= 1'b0;
      wen_reg       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid && ready_reg) begin
            waddr_reg    <= bus.req_addr[ADDR_DEPTH+1:2];
            off_reg      <= bus.req_addr[1:0];
            size_reg     <= bus.req_size;
            we_reg       <= bus.req_we;
            unsigned_reg <= bus.req_unsigned;
            wdata_reg    <= bus.req_wdata;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              state_reg     <= ST_ERROR;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
            end else if (bus.req_we && bus.req_size == SIZE_WORD) begin
              state_reg <= ST_WRITE;
              wen_reg   <= 1'b1;
            end else begin
              // loads and sub-word stores both start with a read
              state_reg <= ST_READ;
              rden_reg  <= 1'b1;
            end
          end else begin
            ready_reg <= 1'b1;
          end
        end
        ST_READ: begin
          if (we_reg) begin
            state_reg <= ST_RMW_WRITE;
            wen_reg   <= 1'b1;
          end else begin
            state_reg     <= ST_LOAD_RSP;
            rsp_valid_reg <= 1'b1;
          end
        end
        ST_RMW_WRITE, ST_WRITE: begin
          state_reg     <= ST_STORE_RSP;
          rsp_valid_reg <= 1'b1;
        end
        default: begin
          // LOAD_RSP, STORE_RSP, ERROR all return to IDLE
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Read data arrives the cycle after rden, i.e. during LOAD_RSP / RMW_WRITE,
  // so the lane logic works directly on mem_data_out in those states.
  lsu_lane_align u_lane_align (
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .byte_off    (off_reg),
    .rd_word     (bus.mem_data_out),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  assign bus.req_ready    = ready_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_err      = rsp_err_reg;
  assign bus.rsp_rdata    = (state_reg == ST_LOAD_RSP) ? load_data : 32'h0;
  assign bus.mem_rden     = rden_reg;
  assign bus.mem_wen      = wen_reg;
  assign bus.mem_byte_sel = MEM_SEL_WORD;
  assign bus.mem_sign     = 1'b0;
  assign bus.mem_addr     = waddr_reg;
  assign bus.mem_data_in  = wen_reg ? store_word : 32'h0;

endmodule
